// File: rtl/audio_dac_player.sv
// audio_dac_player: one-entry sample buffer feeding a 16-bit-per-channel I2S
// serializer driven by an external codec bit clock and frame clock.
// Optional feature: define AUD_HOLD_LAST_EN to replay the last played sample
// on underflow; without it an underflow frame plays silence.
`timescale 1ns/1ps

module audio_dac_player (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bclk,
  input  logic        i_daclrck,
  input  logic        i_en,
  input  logic        mix_audio_valid,
  input  logic [31:0] mix_audio_data,
  output logic        mix_audio_ready,
  output logic        o_aud_dacdat,
  output logic        o_underflow,
  output logic [2:0]  debug
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [1:0]  bclk_sync, lrck_sync;
  logic        bclk_prev, lrck_prev;
  logic        bclk_fall, lrck_fall, lrck_rise;
  logic        load_left, load_right, go_idle;
  logic        out_of_reset;
  logic        buf_full;
  logic [31:0] buf_data;
  logic [31:0] fill_word, frame_word;
  logic [15:0] shift_reg, right_hold;
  logic [4:0]  bit_cnt;
  logic        accept;

  // Two-flop synchronizers plus one history flop for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      bclk_prev <= 1'b0;
      lrck_prev <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], i_bclk};
      lrck_sync <= {lrck_sync[0], i_daclrck};
      bclk_prev <= bclk_sync[1];
      lrck_prev <= lrck_sync[1];
    end
  end

  assign bclk_fall = bclk_prev & ~bclk_sync[1];
  assign lrck_fall = lrck_prev & ~lrck_sync[1];
  assign lrck_rise = ~lrck_prev & lrck_sync[1];

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: frames start on an LRCK fall; a disable takes effect at the next LRCK edge.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    load_left  = 1'b0;
    load_right = 1'b0;
    go_idle    = 1'b0;
    case (state)
      IDLE: begin
        if (lrck_fall && i_en) begin
          state_next = LEFT;
          load_left  = 1'b1;
        end
      end
      LEFT: begin
        if (lrck_rise) begin
          if (i_en) begin
            state_next = RIGHT;
            load_right = 1'b1;
          end else begin
            state_next = IDLE;
            go_idle    = 1'b1;
          end
        end
      end
      RIGHT: begin
        if (lrck_fall) begin
          if (i_en) begin
            state_next = LEFT;
            load_left  = 1'b1;
          end else begin
            state_next = IDLE;
            go_idle    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Holds ready low while reset is asserted and for the first cycle after release.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) out_of_reset <= 1'b0;
    else       out_of_reset <= 1'b1;
  end

  // The slot frees up in the same cycle its sample is loaded, so a new sample
  // can be taken while the old one moves into the shifter.
  assign mix_audio_ready = out_of_reset & i_en & (~buf_full | load_left);
  assign accept          = mix_audio_valid & mix_audio_ready;

  // One-entry holding buffer; an acceptance wins over the load-time clear.
  // NOTE: only the valid flag is reset; the data word is never read while the flag is low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      buf_full <= 1'b0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= mix_audio_data;
    end else if (load_left || go_idle || (state == IDLE && !i_en)) begin
      buf_full <= 1'b0;
    end
  end

`ifdef AUD_HOLD_LAST_EN
  logic [31:0] last_sample;

  // Remembers the last sample actually taken from the buffer for replay on underflow.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                      last_sample <= '0;
    else if (load_left && buf_full) last_sample <= buf_data;
  end

  assign fill_word = last_sample;
`else
  assign fill_word = '0;
`endif

  assign frame_word = buf_full ? buf_data : fill_word;

  // Serializer: MSB first on each BCLK fall, zeros once 16 bits are out.
  // The bit shifted on the fall that coincides with an LRCK edge is the
  // previous channel's LSB, so the load takes effect for the following fall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shift_reg    <= '0;
      right_hold   <= '0;
      bit_cnt      <= '0;
      o_aud_dacdat <= 1'b0;
      o_underflow  <= 1'b0;
    end else begin
      o_underflow <= load_left & ~buf_full;
      if (bclk_fall)
        o_aud_dacdat <= (state != IDLE && bit_cnt < 5'd16) ? shift_reg[15] : 1'b0;
      if (load_left) begin
        shift_reg  <= frame_word[31:16];
        right_hold <= frame_word[15:0];
        bit_cnt    <= '0;
      end else if (load_right) begin
        shift_reg <= right_hold;
        bit_cnt   <= '0;
      end else if (go_idle) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (bclk_fall && state != IDLE && bit_cnt != 5'd16) begin
        shift_reg <= {shift_reg[14:0], 1'b0};
        bit_cnt   <= bit_cnt + 5'd1;
      end
    end
  end

  assign debug = {buf_full, state};

endmodule

// File: tb/tb_audio_dac_player.sv
// tb_audio_dac_player: drives codec BCLK/LRCK frames, feeds samples through a
// valid/ready driver and compares each captured 16-bit word with a queue of
// expected words pushed when the frame stimulus is scheduled.
`timescale 1ns/1ps

module tb_audio_dac_player;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_bclk = 1'b1;
  logic        i_daclrck = 1'b1;
  logic        i_en = 1'b0;
  logic        mix_audio_valid = 1'b0;
  logic [31:0] mix_audio_data = '0;
  logic        mix_audio_ready;
  logic        o_aud_dacdat;
  logic        o_underflow;
  logic [2:0]  debug;

  always #10 i_clk = ~i_clk;

  audio_dac_player dut (
    .i_clk           (i_clk),
    .i_rst           (i_rst),
    .i_bclk          (i_bclk),
    .i_daclrck       (i_daclrck),
    .i_en            (i_en),
    .mix_audio_valid (mix_audio_valid),
    .mix_audio_data  (mix_audio_data),
    .mix_audio_ready (mix_audio_ready),
    .o_aud_dacdat    (o_aud_dacdat),
    .o_underflow     (o_underflow),
    .debug           (debug)
  );

  typedef struct {
    bit          chk;
    logic [15:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] feed_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          uf_count = 0;
  int          frame_no = 0;
  bit          started  = 1'b0;
  logic [15:0] rx       = '0;
  logic [31:0] fill;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Count underflow pulses, sampled mid-cycle.
  always @(negedge i_clk) if (o_underflow === 1'b1) uf_count++;

  // Sample driver: offers the head of feed_q, pops it once the handshake completes.
  initial begin
    bit fire;
    fire = 1'b0;
    forever begin
      @(negedge i_clk);
      if (fire) void'(feed_q.pop_front());
      mix_audio_valid = (feed_q.size() > 0);
      mix_audio_data  = (feed_q.size() > 0) ? feed_q[0] : 32'd0;
      #1 fire = mix_audio_valid && mix_audio_ready;
    end
  end

  task automatic push_frame(input bit chk_l, input bit chk_r, input logic [31:0] s);
    exp_t e;
    e.chk = chk_l; e.word = s[31:16]; exp_q.push_back(e);
    e.chk = chk_r; e.word = s[15:0];  exp_q.push_back(e);
  endtask

  // One LRCK frame of 2 x 16 BCLK periods (640 ns each, edges on i_clk negedges).
  // action: 0 none, 1 reset after 8 left bits, 2 drop enable after 8 left bits.
  task automatic play_frame(input int action, input bit do_offer, input logic [31:0] offer);
    exp_t e;
    frame_no++;
    for (int h = 0; h < 2; h++) begin
      for (int k = 0; k < 16; k++) begin
        i_bclk = 1'b0;
        if (k == 0) i_daclrck = h[0];
        if (h == 0 && k == 0 && do_offer) begin
          #39 feed_q.push_back(offer);
          #281;
        end else if (k == 1 && exp_q.size() > 0 && exp_q[0].chk) begin
          #79 check($sformatf("f%0d h%0d msb latency", frame_no, h), o_aud_dacdat, exp_q[0].word[15]);
          #241;
        end else begin
          #320;
        end
        i_bclk = 1'b1;
        rx = {rx[14:0], o_aud_dacdat};
        if (k == 0) begin
          if (started && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) check($sformatf("f%0d h%0d word", frame_no, h), rx, e.word);
          end
          started = 1'b1;
        end
        if (h == 0 && k == 8 && action == 1) begin
          i_rst = 1'b1;
          #1;
          check("reset dacdat", o_aud_dacdat, 1'b0);
          check("reset ready", mix_audio_ready, 1'b0);
          check("reset debug", debug, 3'b000);
          #159 i_rst = 1'b0;
          #160;
        end else begin
          if (h == 0 && k == 8 && action == 2) i_en = 1'b0;
          #320;
        end
      end
    end
  endtask

  task automatic feed(input logic [31:0] s);
    feed_q.push_back(s);
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst ready", mix_audio_ready, 1'b0);
    check("rst dacdat", o_aud_dacdat, 1'b0);
    check("rst underflow", o_underflow, 1'b0);
    check("rst debug", debug, 3'b000);
    i_rst = 1'b0;
    @(negedge i_clk);
    #1 check("ready while disabled", mix_audio_ready, 1'b0);
    @(negedge i_clk);
    i_en = 1'b1;
    #1 check("ready enabled empty", mix_audio_ready, 1'b1);

    // Nominal frame.
    feed(32'h8001_7FFE);
    #2 check("buffer full idle", debug, 3'b100);
    check("ready full", mix_audio_ready, 1'b0);
    push_frame(1, 1, 32'h8001_7FFE);
    @(negedge i_clk);
    play_frame(0, 0, 0);
    check("nominal no underflow", uf_count, 0);

    // Backpressure with three queued samples.
    feed_q.push_back(32'h0F0F_F0F0);
    feed_q.push_back(32'hAAAA_5555);
    feed(32'h1357_9BDF);
    #2 check("backpressure ready", mix_audio_ready, 1'b0);
    check("one sample taken", feed_q.size(), 2);
    push_frame(1, 1, 32'h0F0F_F0F0);
    push_frame(1, 1, 32'hAAAA_5555);
    push_frame(1, 1, 32'h1357_9BDF);
    play_frame(0, 0, 0);
    play_frame(0, 0, 0);
    play_frame(0, 0, 0);
    check("backpressure drained", feed_q.size(), 0);
    check("backpressure no underflow", uf_count, 0);

    // Underflow after a single sample.
    feed(32'h1234_5678);
    push_frame(1, 1, 32'h1234_5678);
    play_frame(0, 0, 0);
    check("pre-underflow count", uf_count, 0);
`ifdef AUD_HOLD_LAST_EN
    fill = 32'h1234_5678;
`else
    fill = 32'h0;
`endif
    push_frame(1, 1, fill);
    play_frame(0, 0, 0);
    check("underflow pulse once", uf_count, 1);

    // Sample arriving with the LRCK fall into an empty buffer waits one frame.
    push_frame(1, 1, fill);
    push_frame(1, 1, 32'hCAFE_BABE);
    play_frame(0, 1, 32'hCAFE_BABE);
    check("late sample underflow", uf_count, 2);
    play_frame(0, 0, 0);
    check("late sample played", uf_count, 2);

    // Reset in the middle of the left channel.
    feed(32'h5A5A_A5A5);
    push_frame(0, 1, 32'h0);
    play_frame(1, 0, 0);
    feed(32'h6B6B_B6B6);
    #2 check("post-reset buffered", debug, 3'b100);
    push_frame(1, 1, 32'h6B6B_B6B6);
    play_frame(0, 0, 0);
    check("post-reset no underflow", uf_count, 2);

    // Disable mid left half: left finishes, right is silent, buffer cleared.
    feed(32'h3333_4444);
    feed_q.push_back(32'h5555_6666);
    push_frame(1, 1, 32'h3333_0000);
    exp_q[exp_q.size() - 2].word = 16'h3333;
    play_frame(2, 0, 0);
    #2 check("disable idle cleared", debug, 3'b000);
    check("disable sample consumed", feed_q.size(), 0);
    @(negedge i_clk);
    i_en = 1'b1;
    #1 check("re-enable ready", mix_audio_ready, 1'b1);
`ifdef AUD_HOLD_LAST_EN
    fill = 32'h3333_4444;
`else
    fill = 32'h0;
`endif
    push_frame(1, 1, fill);
    @(negedge i_clk);
    play_frame(0, 0, 0);
    check("re-enable underflow", uf_count, 3);

    // Trailing frame so the last right-channel LSB is captured.
    i_en = 1'b0;
    push_frame(0, 0, 32'h0);
    play_frame(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_dac_player.md
AUDIO_DAC_PLAYER -- requirements
Module: audio_dac_player

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset: i_clk  input  1  system clock; i_rst  input  1  asynchronous active-high reset.
REQ-002 Ports SHALL be:
- i_bclk  input  1  codec bit clock, asynchronous to i_clk.
- i_daclrck  input  1  codec DAC frame clock; low = left, high = right.
- i_en  input  1  play enable.
- mix_audio_valid  input  1  sample offered.
- mix_audio_data  input  32  signed sample, left = [31:16], right = [15:0].
- mix_audio_ready  output  1  buffer can accept a sample.
- o_aud_dacdat  output  1  serial DAC data.
- o_underflow  output  1  one-cycle pulse, frame started with no sample buffered.
- debug  output  3  {buffer_full, state[1:0]}.

Function
REQ-003 i_bclk and i_daclrck SHALL each pass through a 2-flop synchronizer followed by an edge detector; the block SHALL require i_clk >= 4x BCLK frequency.
REQ-004 A one-entry holding buffer SHALL be provided; mix_audio_ready SHALL be 1 when the buffer is empty and i_en=1, else 0.
REQ-005 Transfer SHALL occur on a rising i_clk edge with mix_audio_valid=1 and mix_audio_ready=1; the buffer becomes full on the next cycle.
REQ-006 The FSM SHALL have states IDLE=0, LEFT=1, RIGHT=2.
- IDLE: o_aud_dacdat=0; on the first synchronized i_daclrck falling edge while i_en=1 -> LEFT.
- LEFT: at entry, load shift_reg[15:0] from buffer[31:16], load right_hold from buffer[15:0], and mark buffer empty; on i_daclrck rising edge -> RIGHT.
- RIGHT: at entry, load shift_reg from right_hold; on i_daclrck falling edge -> LEFT (new frame).
REQ-007 Serialization SHALL be I2S: the MSB is driven on the first synchronized BCLK falling edge after each LRCK edge, then one bit per subsequent BCLK falling edge, MSB first; after 16 bits o_aud_dacdat SHALL be 0 until the next LRCK edge.
REQ-008 A bit counter (5 bits) SHALL saturate at 16; extra BCLK edges in a half-frame SHALL output 0.
REQ-009 If the buffer is empty at a LEFT entry, o_underflow SHALL pulse for one cycle and the frame SHALL be filled per REQ-015.
REQ-010 If a load (REQ-006) and an acceptance (REQ-005) occur in the same cycle, the buffer SHALL end full with the new sample, and the old sample SHALL be the one loaded.
REQ-011 If a sample is accepted in the same cycle as an LRCK edge but the buffer was empty, the sample SHALL NOT be used for the current frame.
REQ-012 When i_en is deasserted, the current half-frame SHALL finish, then the FSM SHALL go to IDLE and the buffer SHALL be cleared.
REQ-013 Output latency SHALL be the MSB on o_aud_dacdat within 4 i_clk cycles of the physical BCLK falling edge.

Reset
REQ-014 On i_rst:
- state=IDLE; buffer empty; shift_reg=0; right_hold=0; bit counter=0; synchronizers=0.
- mix_audio_ready=0, o_aud_dacdat=0, o_underflow=0.
- Reset mid-frame SHALL abort the frame immediately.
- After release, the block SHALL wait for a fresh i_daclrck falling edge before driving data.

Configuration
REQ-015 The macro AUD_HOLD_LAST_EN SHALL control underflow fill.
- Defined: on underflow the last played 32-bit sample SHALL be replayed (0 after reset).
- Undefined: on underflow both channels SHALL be 0.

Verification
REQ-016 Nominal frame: i_clk 50 MHz, BCLK 1.536 MHz, LRCK 48 kHz, sample 0x8001_7FFE -> left bits 1000000000000001, then right bits 0111111111111110 on o_aud_dacdat, with no o_underflow pulse.
REQ-017 Backpressure: hold mix_audio_valid=1 with 3 distinct samples -> mix_audio_ready low while the buffer is full; exactly one sample is consumed per LRCK frame, in order.
REQ-018 Underflow: no sample offered for frame 2 after 0x1234_5678 -> o_underflow pulses once; frame 2 is all zeros, or 0x1234/0x5678 with AUD_HOLD_LAST_EN.
REQ-019 Simultaneous events: accept 0xAAAA_5555 in the exact cycle the buffered 0x0F0F_F0F0 loads -> frame N plays 0x0F0F/0xF0F0 and frame N+1 plays 0xAAAA/0x5555.
REQ-020 Reset mid-frame: assert i_rst at bit 7 of left -> o_aud_dacdat=0 immediately; after release, output resumes only after the next LRCK falling edge with a newly accepted sample.
